// File: rtl/sram_pkg.sv
// Shared widths, mask bit positions and FSM state encoding for the
// two-port SRAM arbiter.
package sram_pkg;
  localparam int ADDR_W  = 18;
  localparam int DATA_W  = 16;
  localparam int MASK_UB = 1;
  localparam int MASK_LB = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WR_SETUP,
    ST_WR_PULSE,
    ST_WR_HOLD
  } state_e;
endpackage

// File: rtl/sram_rr_arbiter.sv
// Two-way round-robin grant with a last-grant pointer that only moves
// when the granted command is actually accepted.
module sram_rr_arbiter
  import sram_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic req_a_i,
  input  logic req_b_i,
  input  logic accept_i,
  output logic gnt_a_o,
  output logic gnt_b_o
);
  logic last_b_q, last_b_d;

  assign gnt_a_o = req_a_i && (!req_b_i || last_b_q);
  assign gnt_b_o = req_b_i && (!req_a_i || !last_b_q);

  always_comb begin
    last_b_d = last_b_q;
    if (accept_i) last_b_d = gnt_b_o;
  end

  // Pointer resets to B so that A wins the first contended grant.
  always_ff @(posedge clk_i) begin
    if (rst_i) last_b_q <= 1'b1;
    else       last_b_q <= last_b_d;
  end
endmodule

// File: rtl/sram_arbiter.sv
// Two-requester arbiter for an asynchronous 16-bit SRAM with fixed-length
// read and write sequencing.
//
// state       | meaning
// ST_IDLE     | pins idle, accepting a command from the granted port
// ST_RD       | cs/oe low for READ_WAIT cycles, data sampled on last cycle
// ST_WR_SETUP | addr/data driven, we still high
// ST_WR_PULSE | we low for WRITE_PULSE cycles
// ST_WR_HOLD  | we high again, data held one more cycle
module sram_arbiter
  import sram_pkg::*;
#(
  parameter int READ_WAIT   = 2,
  parameter int WRITE_PULSE = 2
) (
  input  logic              io_mainClk,
  input  logic              io_reset,
  input  logic              io_a_cmd_valid,
  output logic              io_a_cmd_ready,
  input  logic              io_a_cmd_write,
  input  logic [ADDR_W-1:0] io_a_cmd_addr,
  input  logic [DATA_W-1:0] io_a_cmd_data,
  input  logic [1:0]        io_a_cmd_mask,
  output logic              io_a_rsp_valid,
  output logic [DATA_W-1:0] io_a_rsp_data,
  input  logic              io_b_cmd_valid,
  output logic              io_b_cmd_ready,
  input  logic              io_b_cmd_write,
  input  logic [ADDR_W-1:0] io_b_cmd_addr,
  input  logic [DATA_W-1:0] io_b_cmd_data,
  input  logic [1:0]        io_b_cmd_mask,
  output logic              io_b_rsp_valid,
  output logic [DATA_W-1:0] io_b_rsp_data,
  output logic [ADDR_W-1:0] io_sram_addr,
  input  logic [DATA_W-1:0] io_sram_dat_read,
  output logic [DATA_W-1:0] io_sram_dat_write,
  output logic              io_sram_dat_writeEnable,
  output logic              io_sram_cs,
  output logic              io_sram_we,
  output logic              io_sram_oe,
  output logic              io_sram_ub,
  output logic              io_sram_lb
);
  localparam logic [3:0] RD_LOAD = 4'(READ_WAIT - 1);
  localparam logic [3:0] WR_LOAD = 4'(WRITE_PULSE - 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [1:0]        mask_q, mask_d;
  logic              owner_q, owner_d;
  logic              rsp_valid_a_q, rsp_valid_a_d, rsp_valid_b_q, rsp_valid_b_d;
  logic [DATA_W-1:0] rsp_data_a_q, rsp_data_a_d, rsp_data_b_q, rsp_data_b_d;
  logic              gnt_a, gnt_b, accept, sel_b;

  assign io_a_cmd_ready = (state_q == ST_IDLE) && gnt_a;
  assign io_b_cmd_ready = (state_q == ST_IDLE) && gnt_b;
  assign accept         = io_a_cmd_ready || io_b_cmd_ready;
  assign sel_b          = io_b_cmd_ready;

  sram_rr_arbiter u_rr (
    .clk_i    (io_mainClk),
    .rst_i    (io_reset),
    .req_a_i  (io_a_cmd_valid),
    .req_b_i  (io_b_cmd_valid),
    .accept_i (accept),
    .gnt_a_o  (gnt_a),
    .gnt_b_o  (gnt_b)
  );

  always_ff @(posedge io_mainClk) begin
    if (io_reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      addr_q        <= '0;
      data_q        <= '0;
      mask_q        <= '0;
      owner_q       <= 1'b0;
      rsp_valid_a_q <= 1'b0;
      rsp_valid_b_q <= 1'b0;
      rsp_data_a_q  <= '0;
      rsp_data_b_q  <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      mask_q        <= mask_d;
      owner_q       <= owner_d;
      rsp_valid_a_q <= rsp_valid_a_d;
      rsp_valid_b_q <= rsp_valid_b_d;
      rsp_data_a_q  <= rsp_data_a_d;
      rsp_data_b_q  <= rsp_data_b_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    addr_d        = addr_q;
    data_d        = data_q;
    mask_d        = mask_q;
    owner_d       = owner_q;
    rsp_valid_a_d = 1'b0;
    rsp_valid_b_d = 1'b0;
    rsp_data_a_d  = rsp_data_a_q;
    rsp_data_b_d  = rsp_data_b_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          owner_d = sel_b;
          addr_d  = sel_b ? io_b_cmd_addr : io_a_cmd_addr;
          data_d  = sel_b ? io_b_cmd_data : io_a_cmd_data;
          mask_d  = sel_b ? io_b_cmd_mask : io_a_cmd_mask;
          if (sel_b ? io_b_cmd_write : io_a_cmd_write) begin
            state_d = ST_WR_SETUP;
            cnt_d   = WR_LOAD;
          end else begin
            state_d = ST_RD;
            cnt_d   = RD_LOAD;
          end
        end
      end
      ST_RD: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_IDLE;
          if (owner_q) begin
            rsp_valid_b_d = 1'b1;
            rsp_data_b_d  = io_sram_dat_read;
          end else begin
            rsp_valid_a_d = 1'b1;
            rsp_data_a_d  = io_sram_dat_read;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_WR_SETUP: state_d = ST_WR_PULSE;
      ST_WR_PULSE: begin
        if (cnt_q == 4'd0) state_d = ST_WR_HOLD;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_WR_HOLD: begin
        state_d       = ST_IDLE;
        rsp_valid_a_d = !owner_q;
        rsp_valid_b_d = owner_q;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    io_sram_cs              = 1'b1;
    io_sram_we              = 1'b1;
    io_sram_oe              = 1'b1;
    io_sram_ub              = 1'b1;
    io_sram_lb              = 1'b1;
    io_sram_dat_writeEnable = 1'b0;
    case (state_q)
      ST_RD: begin
        io_sram_cs = 1'b0;
        io_sram_oe = 1'b0;
        io_sram_ub = !mask_q[MASK_UB];
        io_sram_lb = !mask_q[MASK_LB];
      end
      ST_WR_SETUP, ST_WR_PULSE, ST_WR_HOLD: begin
        io_sram_cs              = 1'b0;
        io_sram_we              = (state_q != ST_WR_PULSE);
        io_sram_ub              = !mask_q[MASK_UB];
        io_sram_lb              = !mask_q[MASK_LB];
        io_sram_dat_writeEnable = 1'b1;
      end
      default: ;
    endcase
  end

  assign io_sram_addr      = addr_q;
  assign io_sram_dat_write = data_q;
  assign io_a_rsp_valid    = rsp_valid_a_q;
  assign io_b_rsp_valid    = rsp_valid_b_q;
  assign io_a_rsp_data     = rsp_data_a_q;
  assign io_b_rsp_data     = rsp_data_b_q;
endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: default-parameter instance with an SRAM
// model, plus a READ_WAIT=1 instance for back-to-back read timing.
module tb_sram_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        a_valid, a_write, b_valid, b_write;
  logic [17:0] a_addr, b_addr;
  logic [15:0] a_data, b_data;
  logic [1:0]  a_mask, b_mask;
  logic        a_ready, b_ready, a_rv, b_rv;
  logic [15:0] a_rd, b_rd;
  logic [17:0] s_addr;
  logic [15:0] s_rdat, s_wdat;
  logic        s_wen, s_cs, s_we, s_oe, s_ub, s_lb;

  logic        c_valid;
  logic [17:0] c_addr;
  logic        c_ready, c_rv, d_ready, d_rv;
  logic [15:0] c_rd, d_rd;
  logic [17:0] s2_addr;
  logic [15:0] s2_rdat, s2_wdat;
  logic        s2_wen, s2_cs, s2_we, s2_oe, s2_ub, s2_lb;

  sram_arbiter u_dut (
    .io_mainClk(clk), .io_reset(rst),
    .io_a_cmd_valid(a_valid), .io_a_cmd_ready(a_ready), .io_a_cmd_write(a_write),
    .io_a_cmd_addr(a_addr), .io_a_cmd_data(a_data), .io_a_cmd_mask(a_mask),
    .io_a_rsp_valid(a_rv), .io_a_rsp_data(a_rd),
    .io_b_cmd_valid(b_valid), .io_b_cmd_ready(b_ready), .io_b_cmd_write(b_write),
    .io_b_cmd_addr(b_addr), .io_b_cmd_data(b_data), .io_b_cmd_mask(b_mask),
    .io_b_rsp_valid(b_rv), .io_b_rsp_data(b_rd),
    .io_sram_addr(s_addr), .io_sram_dat_read(s_rdat), .io_sram_dat_write(s_wdat),
    .io_sram_dat_writeEnable(s_wen), .io_sram_cs(s_cs), .io_sram_we(s_we),
    .io_sram_oe(s_oe), .io_sram_ub(s_ub), .io_sram_lb(s_lb)
  );

  sram_arbiter #(.READ_WAIT(1), .WRITE_PULSE(2)) u_dut_rw1 (
    .io_mainClk(clk), .io_reset(rst),
    .io_a_cmd_valid(c_valid), .io_a_cmd_ready(c_ready), .io_a_cmd_write(1'b0),
    .io_a_cmd_addr(c_addr), .io_a_cmd_data(16'h0000), .io_a_cmd_mask(2'b11),
    .io_a_rsp_valid(c_rv), .io_a_rsp_data(c_rd),
    .io_b_cmd_valid(1'b0), .io_b_cmd_ready(d_ready), .io_b_cmd_write(1'b0),
    .io_b_cmd_addr(18'h0), .io_b_cmd_data(16'h0000), .io_b_cmd_mask(2'b00),
    .io_b_rsp_valid(d_rv), .io_b_rsp_data(d_rd),
    .io_sram_addr(s2_addr), .io_sram_dat_read(s2_rdat), .io_sram_dat_write(s2_wdat),
    .io_sram_dat_writeEnable(s2_wen), .io_sram_cs(s2_cs), .io_sram_we(s2_we),
    .io_sram_oe(s2_oe), .io_sram_ub(s2_ub), .io_sram_lb(s2_lb)
  );

  // Small SRAM model; only low address bits are decoded.
  logic [15:0] mem [0:1023];
  assign s_rdat  = mem[s_addr[9:0]];
  assign s2_rdat = s2_addr[15:0] ^ 16'hA5A5;
  always @(posedge clk) begin
    if (!s_cs && !s_we) begin
      if (!s_lb) mem[s_addr[9:0]][7:0]  <= s_wdat[7:0];
      if (!s_ub) mem[s_addr[9:0]][15:8] <= s_wdat[15:8];
    end
  end

  int n_vec = 0;
  int n_err = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("oe_low_with_wen", 32'(!s_oe && s_wen), 32'd0);
      chk("rsp_both_ports", 32'(a_rv && b_rv), 32'd0);
      chk("oe_low_with_wen_rw1", 32'(!s2_oe && s2_wen), 32'd0);
      chk("rsp_both_ports_rw1", 32'(c_rv && d_rv), 32'd0);
    end
  end

  bit h_we [0:31], h_oe [0:31], h_cs [0:31], h_ub [0:31], h_lb [0:31], h_wen [0:31];

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; c_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic issue(input bit p, input bit wr, input logic [17:0] ad,
                       input logic [15:0] d, input logic [1:0] m);
    if (!p) begin a_valid = 1'b1; a_write = wr; a_addr = ad; a_data = d; a_mask = m; end
    else    begin b_valid = 1'b1; b_write = wr; b_addr = ad; b_data = d; b_mask = m; end
  endtask

  task automatic wait_accept(input bit p, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      if ((p ? b_ready : a_ready) === 1'b1) begin
        @(posedge clk);
        #1;
        if (!p) a_valid = 1'b0; else b_valid = 1'b0;
        ok = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
  endtask

  task automatic wait_rsp(input bit p, output int lat);
    lat = -1;
    for (int k = 1; k <= 30 && lat < 0; k++) begin
      @(negedge clk);
      h_we[k] = s_we; h_oe[k] = s_oe; h_cs[k] = s_cs;
      h_ub[k] = s_ub; h_lb[k] = s_lb; h_wen[k] = s_wen;
      if ((p ? b_rv : a_rv) === 1'b1) lat = k;
    end
  endtask

  task automatic xfer(input bit p, input bit wr, input logic [17:0] ad, input logic [15:0] d,
                      input logic [1:0] m, output int lat, output logic [15:0] rdata);
    bit ok;
    issue(p, wr, ad, d, m);
    wait_accept(p, ok);
    chk("accept", 32'(ok), 32'd1);
    wait_rsp(p, lat);
    rdata = p ? b_rd : a_rd;
  endtask

  int          lat;
  logic [15:0] rdata;
  int          ng;
  bit          g [0:3];
  bit          seen;
  bit          ok;

  initial begin
    rst = 1'b1;
    a_valid = 1'b0; a_write = 1'b0; a_addr = '0; a_data = '0; a_mask = '0;
    b_valid = 1'b0; b_write = 1'b0; b_addr = '0; b_data = '0; b_mask = '0;
    c_valid = 1'b0; c_addr = '0;
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;

    do_reset();
    mon_en = 1'b1;
    chk("rst_cs", 32'(s_cs), 32'd1);
    chk("rst_we", 32'(s_we), 32'd1);
    chk("rst_oe", 32'(s_oe), 32'd1);
    chk("rst_ublb", 32'({s_ub, s_lb}), 32'h3);
    chk("rst_wen", 32'(s_wen), 32'd0);
    chk("rst_addr", 32'(s_addr), 32'h0);
    chk("rst_rsp_valid", 32'({a_rv, b_rv}), 32'h0);
    chk("rst_rsp_data", 32'({a_rd, b_rd}), 32'h0);
    chk("rst_ready", 32'({a_ready, b_ready}), 32'h0);

    // Write then read back the same halfword.
    xfer(1'b0, 1'b1, 18'h00010, 16'hBEEF, 2'b11, lat, rdata);
    chk("wr_latency", 32'(lat), 32'd5);
    chk("wr_we_seq", 32'({h_we[1], h_we[2], h_we[3], h_we[4], h_we[5]}), 32'b10011);
    chk("wr_wen_seq", 32'({h_wen[1], h_wen[2], h_wen[3], h_wen[4], h_wen[5]}), 32'b11110);
    chk("wr_cs_seq", 32'({h_cs[1], h_cs[2], h_cs[3], h_cs[4], h_cs[5]}), 32'b00001);
    chk("wr_rsp_data_kept", 32'(rdata), 32'h0);
    xfer(1'b0, 1'b0, 18'h00010, 16'h0000, 2'b11, lat, rdata);
    chk("rd_latency", 32'(lat), 32'd3);
    chk("rd_data", 32'(rdata), 32'hBEEF);
    chk("rd_oe_seq", 32'({h_oe[1], h_oe[2], h_oe[3]}), 32'b001);
    chk("idle_addr_hold", 32'(s_addr), 32'h00010);

    // Byte-masked write over 0xFFFF, then a mask=00 write that must not land.
    xfer(1'b0, 1'b1, 18'h00020, 16'hFFFF, 2'b11, lat, rdata);
    chk("fill_latency", 32'(lat), 32'd5);
    xfer(1'b0, 1'b1, 18'h00020, 16'h1234, 2'b01, lat, rdata);
    chk("lb_in_pulse", 32'({h_lb[2], h_lb[3]}), 32'b00);
    chk("ub_in_pulse", 32'({h_ub[2], h_ub[3]}), 32'b11);
    xfer(1'b0, 1'b1, 18'h00020, 16'h0000, 2'b00, lat, rdata);
    chk("mask00_latency", 32'(lat), 32'd5);
    chk("mask00_ublb", 32'({h_ub[2], h_lb[2], h_ub[3], h_lb[3]}), 32'hF);
    xfer(1'b1, 1'b0, 18'h00020, 16'h0000, 2'b11, lat, rdata);
    chk("b_rd_latency", 32'(lat), 32'd3);
    chk("b_rd_masked_data", 32'(rdata), 32'hFF34);

    // Both ports contending from reset: A, B, A, B.
    do_reset();
    issue(1'b0, 1'b0, 18'h00010, 16'h0, 2'b11);
    issue(1'b1, 1'b0, 18'h00020, 16'h0, 2'b11);
    ng = 0;
    for (int i = 0; i < 80 && ng < 4; i++) begin
      #1;
      chk("both_ready", 32'(a_ready && b_ready), 32'd0);
      if (a_ready || b_ready) begin
        g[ng] = b_ready;
        ng++;
      end
      @(negedge clk);
    end
    chk("rr_grants", 32'(ng), 32'd4);
    chk("rr_order", 32'({g[0], g[1], g[2], g[3]}), 32'b0101);

    // Reset in the second WR_PULSE cycle aborts the write.
    do_reset();
    issue(1'b0, 1'b1, 18'h00030, 16'h5555, 2'b11);
    wait_accept(1'b0, ok);
    chk("abort_accept", 32'(ok), 32'd1);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("abort_pre_we", 32'(s_we), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_pins", 32'({s_we, s_cs, s_wen}), 32'b110);
    seen = (a_rv || b_rv);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      seen = seen || a_rv || b_rv;
    end
    chk("abort_no_rsp", 32'(seen), 32'd0);
    issue(1'b0, 1'b0, 18'h00010, 16'h0, 2'b11);
    issue(1'b1, 1'b0, 18'h00020, 16'h0, 2'b11);
    #1;
    chk("abort_next_grant", 32'({a_ready, b_ready}), 32'b10);
    wait_accept(1'b0, ok);
    b_valid = 1'b0;
    wait_rsp(1'b0, lat);
    chk("abort_followup_rd", 32'(a_rd), 32'hBEEF);

    // READ_WAIT=1 instance: back-to-back reads.
    @(negedge clk);
    c_valid = 1'b1;
    c_addr  = 18'h3FFFF;
    #1;
    chk("rw1_ready1", 32'(c_ready), 32'd1);
    @(posedge clk);
    #1;
    c_addr = 18'h00000;
    @(negedge clk);
    chk("rw1_k1_rv", 32'(c_rv), 32'd0);
    chk("rw1_k1_ready", 32'(c_ready), 32'd0);
    chk("rw1_k1_pins", 32'({s2_cs, s2_oe, s2_we, s2_ub, s2_lb}), 32'b00100);
    @(negedge clk);
    chk("rw1_k2_rv", 32'(c_rv), 32'd1);
    chk("rw1_k2_data", 32'(c_rd), 32'h5A5A);
    #1;
    chk("rw1_k2_ready", 32'(c_ready), 32'd1);
    @(posedge clk);
    #1;
    c_valid = 1'b0;
    @(negedge clk);
    chk("rw1_k3_rv", 32'(c_rv), 32'd0);
    @(negedge clk);
    chk("rw1_k4_rv", 32'(c_rv), 32'd1);
    chk("rw1_k4_data", 32'(c_rd), 32'hA5A5);
    chk("rw1_b_quiet", 32'({d_ready, d_rd}), 32'h0);
    chk("rw1_wdat", 32'(s2_wdat), 32'h0);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got time limit, expected bench completion");
    $fatal(1);
  end
endmodule
